// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: channel state encoding and a width helper.
package key_pkg;

  typedef enum logic [1:0] {
    UP        = 2'd0,
    DOWN_PEND = 2'd1,
    DOWN      = 2'd2,
    UP_PEND   = 2'd3
  } key_state_t;

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: 2-flop synchroniser, debounce FSM, registered level/press/release.
// Auto-repeat press pulses while held are added when KEY_REPEAT_EN is defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int            CW       = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("key_debounce_ch: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
  end

  logic [1:0]    sync_q;
  logic          s;
  key_state_t    state;
  logic [CW-1:0] cnt;

  assign s = ~sync_q[1];

`ifdef KEY_REPEAT_EN
  localparam int RW = clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_last;
  logic          rpt_first;

  // First repeat waits the long delay, later ones the short period.
  assign rpt_last = rpt_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      state       <= UP;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt     <= '0;
      rpt_first   <= 1'b1;
`endif
    end else begin
      sync_q      <= {sync_q[0], key_raw};
      key_press   <= 1'b0;
      key_release <= 1'b0;
`ifdef KEY_REPEAT_EN
      if (state != DOWN) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end
`endif
      case (state)
        UP: begin
          if (s) begin
            state <= DOWN_PEND;
            cnt   <= CW'(1);
          end
        end
        DOWN_PEND: begin
          if (!s) begin
            state <= UP;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= DOWN;
            cnt       <= '0;
            key_level <= 1'b1;
            key_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DOWN: begin
          if (!s) begin
            state <= UP_PEND;
            cnt   <= CW'(1);
`ifdef KEY_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
          end else if (rpt_cnt == rpt_last) begin
            key_press <= 1'b1;
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
`endif
          end
        end
        UP_PEND: begin
          if (s) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= UP;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= UP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Debounces NUM_KEYS active-low pushbuttons into clean level and one-cycle press/release pulses.
// Auto-repeat on held keys is enabled by defining KEY_REPEAT_EN.
module key_debouncer
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk        (CLOCK_50),
      .rst_n      (resetn),
      .key_raw    (KEY[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

endmodule
